// File: rtl/ps2_key_encoder.sv
// PS/2 device-to-host deserializer that folds E0/F0/E1 prefixes
// into the 11-bit toggle-encoded ps2_key event bus.
module ps2_key_encoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 24000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic          clk_m_q, clk_s_q;
  logic          dat_m_q, dat_s_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_q, filt_d;
  logic          fall;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          rdy_q, rdy_d;
  logic          bad_q, bad_d;
  logic          tmo;

  logic [10:0]   key_q, key_d;
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic [2:0]    skip_q, skip_d;
  logic          frame_err_q, frame_err_d;

  // Pins idle high, so the synchronizers reset to 1.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      clk_m_q <= 1'b1;
      clk_s_q <= 1'b1;
      dat_m_q <= 1'b1;
      dat_s_q <= 1'b1;
    end else begin
      clk_m_q <= ps2_clk;
      clk_s_q <= clk_m_q;
      dat_m_q <= ps2_data;
      dat_s_q <= dat_m_q;
    end
  end

  always_comb begin
    filt_cnt_d = '0;
    filt_d     = filt_q;
    if (clk_s_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    rdy_d     = 1'b0;
    bad_d     = 1'b0;
    tmo       = 1'b0;
    tcnt_d    = '0;
    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shreg_d   = {dat_s_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = dat_s_q;
          state_d = STOP;
        end
        STOP: begin
          // Odd parity over data plus parity bit, and a high stop bit.
          rdy_d   = dat_s_q & (^{shreg_q, par_q});
          bad_d   = ~rdy_d;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tcnt_q == TW'(TIMEOUT - 1)) begin
        tmo     = 1'b1;
        state_d = IDLE;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    key_d  = key_q;
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;
    unique case (1'b1)
      bad_q: begin
        ext_d  = 1'b0;
        rel_d  = 1'b0;
        skip_d = '0;
      end
      tmo: begin
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
      rdy_q: begin
        if (skip_q != 3'd0) begin
          skip_d = skip_q - 1'b1;
        end else if (shreg_q == 8'hE1) begin
          skip_d = 3'd7;
        end else if (shreg_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (shreg_q == 8'hF0) begin
          rel_d = 1'b1;
        end else begin
          key_d = {~key_q[10], ~rel_q, ext_q, shreg_q};
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign frame_err_d = bad_q | tmo;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      filt_cnt_q  <= '0;
      filt_q      <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tcnt_q      <= '0;
      rdy_q       <= 1'b0;
      bad_q       <= 1'b0;
      key_q       <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      skip_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      filt_cnt_q  <= filt_cnt_d;
      filt_q      <= filt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      tcnt_q      <= tcnt_d;
      rdy_q       <= rdy_d;
      bad_q       <= bad_d;
      key_q       <= key_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      skip_q      <= skip_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule
